// File: rtl/nano20k_led_status.sv
// Board status LEDs for the Nano20K build: heartbeat, stretched UART/flash activity,
// post-reset boot lamp and a sticky flash-stall flag, all on one clock.
module nano20k_led_status #(
  parameter int unsigned CLK_HZ         = 27_000_000,
  parameter int unsigned HEARTBEAT_HZ   = 1,
  parameter int unsigned STRETCH_CYCLES = 2_700_000,
  parameter int unsigned STALL_CYCLES   = 27_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       uart_txd,
  input  logic       flash_spi_cs_n,
  output logic [5:0] led
);

  localparam int unsigned HALF = (HEARTBEAT_HZ == 0) ? 0 : CLK_HZ / (2 * HEARTBEAT_HZ);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW = $clog2(STALL_CYCLES + 1);

  localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH_CYCLES);
  localparam logic [HW-1:0] HALF_M1    = HW'(HALF - 1);
  localparam logic [TW-1:0] STALL_MAX  = TW'(STALL_CYCLES);
  localparam logic [5:0]    BOOT_ON    = 6'b010000;
  localparam logic [5:0]    LED_RST    = LED_ACTIVE_LOW ? ~BOOT_ON : BOOT_ON;

  if (HALF == 0 || STRETCH_CYCLES == 0 || STALL_CYCLES == 0) begin : g_bad_params
    $fatal(1, "nano20k_led_status: HALF, STRETCH_CYCLES and STALL_CYCLES must all be >= 1");
  end

  // Input flops idle at 1 so leaving reset never looks like a falling edge.
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic tx_q, tx_prev_q;
  logic cs_q, cs_prev_q;

  logic [SW-1:0] str_q [3];
  logic [SW-1:0] str_d [3];
  logic [SW-1:0] boot_q, boot_d;
  logic [HW-1:0] presc_q, presc_d;
  logic          hb_q, hb_d;
  logic [TW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_flag_q, stall_flag_d;
  logic [2:0]    ev;
  logic [5:0]    on;
  logic [5:0]    led_q, led_d;

  assign ev = {cs_prev_q & ~cs_q, tx_prev_q & ~tx_q, rx_prev_q & ~rx_s2_q};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      str_d[i] = str_q[i];
      // A fresh event reloads even while counting down, so retriggers never gap.
      if (ev[i]) begin
        str_d[i] = STRETCH_LD;
      end else if (str_q[i] != '0) begin
        str_d[i] = str_q[i] - SW'(1);
      end
    end

    boot_d = boot_q;
    if (boot_q != '0) begin
      boot_d = boot_q - SW'(1);
    end

    presc_d = presc_q + HW'(1);
    hb_d    = hb_q;
    if (presc_q == HALF_M1) begin
      presc_d = '0;
      hb_d    = ~hb_q;
    end

    stall_cnt_d = '0;
    if (!cs_q) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + TW'(1);
    end
    stall_flag_d = stall_flag_q | (stall_cnt_d == STALL_MAX);

    on = {stall_flag_q, boot_q != '0, str_q[2] != '0, str_q[1] != '0, str_q[0] != '0, hb_q};
    led_d = LED_ACTIVE_LOW ? ~on : on;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      tx_q         <= 1'b1;
      tx_prev_q    <= 1'b1;
      cs_q         <= 1'b1;
      cs_prev_q    <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        str_q[i] <= '0;
      end
      boot_q       <= STRETCH_LD;
      presc_q      <= '0;
      hb_q         <= 1'b0;
      stall_cnt_q  <= '0;
      stall_flag_q <= 1'b0;
      led_q        <= LED_RST;
    end else begin
      rx_s1_q      <= uart_rxd;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      tx_q         <= uart_txd;
      tx_prev_q    <= tx_q;
      cs_q         <= flash_spi_cs_n;
      cs_prev_q    <= cs_q;
      for (int i = 0; i < 3; i++) begin
        str_q[i] <= str_d[i];
      end
      boot_q       <= boot_d;
      presc_q      <= presc_d;
      hb_q         <= hb_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_flag_q <= stall_flag_d;
      led_q        <= led_d;
    end
  end

  assign led = led_q;

endmodule
